// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and the ALU:
// state codes, opcode/funct values, ALU selects, mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) ||
           (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: counts while en, clears on clr.
// Ports: clk, rst, en, clr in; tc high when this cycle is the TIMEOUT-th wait.
module mc_wait_timer #(
  parameter int WAIT_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  // cnt_q holds completed wait cycles, so the current
  // cycle is wait number cnt_q+1.
  localparam logic [WAIT_W-1:0] TERM = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  assign tc = en && (cnt_q == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main controller with ready-based memory handshake and bus timeout.
// Ports: clk, rst, op, funct, zero, mem_ready in; datapath strobes/selects, illegal, bus_err, state out.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_sel,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   bus_err_q, bus_err_d;
  logic   waiting, tmr_clr, tmr_tc;
  logic   rtype_ok;

  assign rtype_ok = (funct == FN_ADDU) || (funct == FN_SUBU);

  // A wait cycle is a memory state without ready; the
  // counter restarts on ready or on any state change.
  assign waiting = is_mem_state(state_q) && !mem_ready;
  assign tmr_clr = !waiting || (state_d != state_q);

  mc_wait_timer #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (waiting),
    .clr (tmr_clr),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)   state_d = S_DECODE;
        else if (tmr_tc) state_d = S_ERR;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE: state_d = rtype_ok ? S_EXEC_R : S_FETCH;
          OP_ORI:   state_d = S_EXEC_I;
          OP_LW:    state_d = S_ADDR;
          OP_SW:    state_d = S_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_ADDR:
        state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)   state_d = S_WB_MEM;
        else if (tmr_tc) state_d = S_ERR;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)   state_d = S_FETCH;
        else if (tmr_tc) state_d = S_ERR;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus_err_d = bus_err_q || (state_d == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = 1'b0;
    alu_sel    = ALU_ADD;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        ext_op    = 1'b1;
        case (op)
          OP_RTYPE: illegal = !rtype_ok;
          OP_ORI, OP_LW, OP_SW,
          OP_BEQ, OP_J: illegal = 1'b0;
          default:  illegal = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_sel   = ALU_OR;
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        reg_dst = (op == OP_RTYPE);
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = zero;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with TIMEOUT=4.
// Drives inputs and checks outputs at the falling edge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_req, mem_we, reg_we;
  logic       reg_dst, mem_to_reg, alu_src_a, ext_op;
  logic [1:0] alu_src_b, alu_sel, pc_src;
  logic       illegal, bus_err;
  logic [3:0] state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_W(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_sel    (alu_sel),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .state      (state)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // all strobes packed for "everything quiet" checks
  function automatic int strobes();
    return {pc_we, ir_we, mem_req, mem_we, reg_we,
            reg_dst, mem_to_reg, alu_src_a, ext_op,
            alu_src_b, alu_sel, pc_src, illegal};
  endfunction

  initial begin
    rst = 1'b1; op = '0; funct = '0;
    zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_outs", strobes(), 0);
    chk("rst_berr", bus_err, 0);
    rst = 1'b0;
    #1;
    chk("idle_state", state, 0);
    chk("idle_outs", strobes(), 0);
    tick();

    // addu
    chk("addu_f", state, 1);
    chk("f_memreq", mem_req, 1);
    chk("f_pcwe", pc_we, 1);
    chk("f_irwe", ir_we, 1);
    chk("f_srcb", alu_src_b, 1);
    op = 6'b000000; funct = 6'b100001;
    tick();
    chk("addu_d", state, 2);
    chk("d_srcb", alu_src_b, 3);
    chk("d_ext", ext_op, 1);
    chk("d_ill", illegal, 0);
    tick();
    chk("addu_x", state, 3);
    chk("addu_sel", alu_sel, 0);
    chk("addu_srca", alu_src_a, 1);
    chk("addu_rwe_x", reg_we, 0);
    tick();
    chk("addu_wb", state, 8);
    chk("addu_rwe", reg_we, 1);
    chk("addu_rdst", reg_dst, 1);
    tick();
    chk("addu_ret", state, 1);
    chk("addu_rwe_f", reg_we, 0);

    // subu
    funct = 6'b100011;
    tick();
    tick();
    chk("subu_x", state, 3);
    chk("subu_sel", alu_sel, 1);
    tick();
    tick();
    chk("subu_ret", state, 1);

    // lw with 3 wait cycles in MEM_RD
    op = 6'b100011; funct = 6'b000000;
    tick();
    chk("lw_d", state, 2);
    tick();
    chk("lw_a", state, 5);
    chk("lw_a_srcb", alu_src_b, 2);
    chk("lw_a_ext", ext_op, 1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_rd_wait", state, 6);
      chk("lw_rd_req", mem_req, 1);
      chk("lw_rd_we", mem_we, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_last", state, 6);
    chk("lw_rd_req4", mem_req, 1);
    tick();
    chk("lw_wb", state, 9);
    chk("lw_rwe", reg_we, 1);
    chk("lw_m2r", mem_to_reg, 1);
    chk("lw_rdst", reg_dst, 0);
    tick();
    chk("lw_ret", state, 1);

    // sw
    op = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_wr", state, 7);
    chk("sw_req", mem_req, 1);
    chk("sw_we", mem_we, 1);
    tick();
    chk("sw_ret", state, 1);

    // ori
    op = 6'b001101;
    tick();
    tick();
    chk("ori_x", state, 4);
    chk("ori_sel", alu_sel, 2);
    chk("ori_srcb", alu_src_b, 2);
    chk("ori_ext", ext_op, 0);
    tick();
    chk("ori_wb", state, 8);
    chk("ori_rdst", reg_dst, 0);
    tick();
    chk("ori_ret", state, 1);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick();
    tick();
    chk("beq1_b", state, 10);
    chk("beq1_pcwe", pc_we, 1);
    chk("beq1_pcsrc", pc_src, 1);
    chk("beq1_sel", alu_sel, 1);
    tick();
    chk("beq1_ret", state, 1);
    zero = 1'b0;
    tick();
    tick();
    chk("beq0_b", state, 10);
    chk("beq0_pcwe", pc_we, 0);
    tick();
    chk("beq0_ret", state, 1);

    // j
    op = 6'b000010;
    tick();
    tick();
    chk("j_s", state, 11);
    chk("j_pcwe", pc_we, 1);
    chk("j_pcsrc", pc_src, 2);
    tick();
    chk("j_ret", state, 1);

    // illegal opcode
    op = 6'b111111;
    tick();
    chk("ill_d", state, 2);
    chk("ill_pulse", illegal, 1);
    chk("ill_rwe", reg_we, 0);
    chk("ill_req", mem_req, 0);
    tick();
    chk("ill_ret", state, 1);
    chk("ill_clr", illegal, 0);

    // illegal R-type funct
    op = 6'b000000; funct = 6'b111111;
    tick();
    chk("illf_pulse", illegal, 1);
    tick();
    chk("illf_ret", state, 1);

    // timeout in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait", state, 1);
      chk("to_pcwe", pc_we, 0);
      tick();
    end
    chk("to_err", state, 12);
    chk("to_berr", bus_err, 1);
    chk("to_quiet", strobes(), 0);
    mem_ready = 1'b1;
    tick();
    chk("to_stay", state, 12);
    chk("to_sticky", bus_err, 1);

    // reset clears ERR
    rst = 1'b1;
    #1;
    chk("to_rst_state", state, 0);
    chk("to_rst_berr", bus_err, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rep_f", state, 1);

    // ready on the 4th wait cycle wins
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    chk("rep_still_f", state, 1);
    mem_ready = 1'b1;
    tick();
    chk("rep_d", state, 2);
    chk("rep_berr", bus_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle main controller that sits directly upstream of the ALU.
- Each cycle it drives the ALU operation select, the ALU operand muxes, and the PC/IR/regfile/memory strobes, based on its state, the IR opcode/funct fields and the ALU zero flag.
- Converts the datapath from single-cycle to multicycle with a ready-based memory handshake and a bus-timeout error.

Parameters:
- WAIT_W, 8, width of the memory-wait counter.
- TIMEOUT, 255, number of consecutive mem_ready-low cycles in a memory state before a bus error (must be < 2**WAIT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- op  in  6  IR[31:26], stable from the cycle after FETCH completes.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (valid only for ALU sel 01).
- mem_ready  in  1  memory completes the current access this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write access (qualified by mem_req).
- reg_we  out  1  regfile write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  1 = write-back from memory data register.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- ext_op  out  1  0 = zero-extend, 1 = sign-extend.
- alu_sel  out  2  00 = add, 01 = sub, 10 = or.
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- illegal  out  1  one-cycle pulse when an undecodable instruction is seen.
- bus_err  out  1  sticky; set on timeout, cleared only by rst.
- state  out  4  current state code (debug).

Behaviour:
- Supported instructions:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - ori: op 001101.
  - lw: op 100011.
  - sw: op 101011.
  - beq: op 000100.
  - j: op 000010.
- State codes: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JUMP 11, ERR 12.
- Output style:
  - Moore outputs, decoded combinationally from the registered state, plus op/funct/zero/mem_ready where stated.
  - Any strobe not listed for a state is 0. Mux selects not listed are 0.
- Reset:
  - State goes to IDLE, wait counter to 0, bus_err to 0.
  - All outputs are 0; state = 0.
  - IDLE always moves to FETCH on the next clock.
- FETCH:
  - mem_req=1, alu_src_a=0, alu_src_b=01, alu_sel=00, pc_src=00.
  - pc_we = ir_we = mem_ready.
  - Moves to DECODE when mem_ready=1; otherwise stays.
- DECODE:
  - alu_src_a=0, alu_src_b=11, ext_op=1, alu_sel=00 (precomputes the branch target).
  - Next state by instruction: R-type → EXEC_R; ori → EXEC_I; lw/sw → ADDR; beq → BRANCH; j → JUMP.
  - Any other op, or op 000000 with another funct: illegal=1 this cycle, then FETCH (instruction skipped; PC already advanced).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_sel = 00 for addu, 01 for subu → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_sel=10 → WB_ALU.
- WB_ALU: reg_we=1, reg_dst = 1 if op==0 else 0 → FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_sel=00 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_we=0. Moves to WB_MEM on mem_ready; otherwise stays.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1. Moves to FETCH on mem_ready; otherwise stays.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=01, pc_src=01, pc_we=zero → FETCH.
- JUMP: pc_src=10, pc_we=1 → FETCH.
- Minimum cycle counts with zero-wait memory:
  - addu/subu/ori: 4.
  - lw: 5.
  - sw: 4.
  - beq/j: 3.
  - Each memory wait cycle adds 1.
- Wait counter and timeout:
  - Counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When the counter equals TIMEOUT with mem_ready still 0: go to ERR and set bus_err.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT completes the access normally (ready wins).
- ERR: all strobes 0; stays in ERR until rst.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- rst asserted mid-wait or mid-instruction: the access is abandoned immediately (asynchronous) and the controller restarts from IDLE.

Decomposition:
- Shared package mc_pkg holds:
  - state codes;
  - opcode/funct constants;
  - ALU_ADD/ALU_SUB/ALU_OR select codes;
  - alu_src_b and pc_src encodings.
- The ALU uses the same select constants from mc_pkg.
- One natural sub-module, mc_wait_timer: WAIT_W counter with clear and terminal-count flag.
- State register, next-state logic and output decode stay in mc_ctrl.

Test Plan:
- rst high, then release, mem_ready=1 always → state 0 for the first post-reset edge, then 1; all outputs 0 while in IDLE.
- addu (op 0, funct 100001), zero-wait → states 1,2,3,8,1; alu_sel=00 in EXEC_R; reg_we=1 and reg_dst=1 exactly in cycle 4.
- lw with mem_ready low for 3 cycles in MEM_RD → states 1,2,5,6,6,6,6,9; mem_req held high all 4 MEM_RD cycles; WB_MEM has reg_we=1, mem_to_reg=1.
- beq with zero=1, then again with zero=0 → pc_we=1 with pc_src=01 in BRANCH for the first; pc_we=0 for the second; both return to FETCH after 3 cycles.
- op 111111 → illegal=1 for one cycle in DECODE, next state FETCH, no reg_we/mem_req pulse.
- mem_ready held 0 in FETCH with TIMEOUT=4 → ERR after the 4th wait cycle, bus_err=1 sticky until rst; a repeat run with ready=1 on the 4th cycle → DECODE, no bus_err.
